// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive front end: FSM state type,
// default framing constants and the half-bit timing helper.
package uart_rx_pkg;

   localparam int DEFAULT_CLKS_PER_BIT = 10;
   localparam int DEFAULT_DATA_BITS    = 8;

   typedef enum logic [2:0] {
      IDLE,
      START_CHK,
      RECV,
      STOP_CHK,
      STORE
   } rx_state_t;

   // Cycles from the detected start edge to the middle of the start bit.
   function automatic int half_bit(input int clks_per_bit);
      return clks_per_bit / 2;
   endfunction

endpackage

// File: rtl/uart_rx_frontend_if.sv
// Write-side connection between the receive front end and rx_fifo.
// The front end is the master: it drives the write strobe and byte and
// observes the fifo full flag.
interface uart_rx_frontend_if
   import uart_rx_pkg::*;
#(
   parameter int DATA_BITS = DEFAULT_DATA_BITS
);

   logic                 w_enable;
   logic [DATA_BITS-1:0] w_data;
   logic                 fifo_full;

   modport master (
      output w_enable,
      output w_data,
      input  fifo_full
   );

   modport slave (
      input  w_enable,
      input  w_data,
      output fifo_full
   );

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter. The FSM loads it with the number of cycles to
// the next sample point; expire is high on the cycle that sample is due.
// Once it reaches zero it stays there until reloaded, so it never wraps.
module uart_bit_timer
   import uart_rx_pkg::*;
#(
   parameter  int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   localparam int TW           = $clog2(CLKS_PER_BIT + 1)
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          load,
   input  logic [TW-1:0] load_val,
   output logic          expire
);

   logic [TW-1:0] count;

   // Count down towards the next sample point; a load always wins.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - TW'(1);
      end
   end

   assign expire = (count == TW'(1));

endmodule

// File: rtl/uart_rx_frontend.sv
// Serial-to-parallel receive front end. Synchronises the RX line, finds
// and validates the start bit, samples each data bit at mid-bit, checks
// the stop bit and writes good bytes into rx_fifo with a one-cycle strobe.
// Framing and overrun problems are reported through sticky flags.
module uart_rx_frontend
   import uart_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               serial_in,
   input  logic               clr_error,
   uart_rx_frontend_if.master fifo_if,
   output logic               framing_error,
   output logic               overrun_error,
   output logic               rx_busy
);

   localparam int TW = $clog2(CLKS_PER_BIT + 1);
   localparam int CW = $clog2(DATA_BITS + 1);

   localparam logic [TW-1:0] HALF_LOAD = TW'(half_bit(CLKS_PER_BIT));
   localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_BITS - 1);

   logic                 sync_1;
   logic                 sync_2;
   logic                 sync_prev;
   logic                 fall_edge;

   rx_state_t            state;
   rx_state_t            next_state;

   logic                 timer_load;
   logic [TW-1:0]        timer_val;
   logic                 timer_expire;

   logic                 start_ok;
   logic                 shift_bit;
   logic                 set_framing;
   logic                 set_overrun;
   logic                 store_byte;

   logic [CW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shift_reg;
   logic [DATA_BITS-1:0] w_data_reg;

   // Two-flop synchronizer plus one history flop for edge detection; all
   // reset to the idle-high level so reset release never looks like a start.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sync_1    <= 1'b1;
         sync_2    <= 1'b1;
         sync_prev <= 1'b1;
      end else begin
         sync_1    <= serial_in;
         sync_2    <= sync_1;
         sync_prev <= sync_2;
      end
   end

   assign fall_edge = sync_prev & ~sync_2;

   uart_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk     (clk),
      .n_rst   (n_rst),
      .load    (timer_load),
      .load_val(timer_val),
      .expire  (timer_expire)
   );

   // Frame state register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and per-cycle control: every sample point is a timer expiry,
   // and the timer is re-armed for a full bit whenever another sample follows.
   always_comb begin
      next_state  = state;
      timer_load  = 1'b0;
      timer_val   = FULL_LOAD;
      start_ok    = 1'b0;
      shift_bit   = 1'b0;
      set_framing = 1'b0;
      set_overrun = 1'b0;
      store_byte  = 1'b0;
      case (state)
         IDLE: begin
            if (fall_edge) begin
               next_state = START_CHK;
               timer_load = 1'b1;
               timer_val  = HALF_LOAD;
            end
         end
         START_CHK: begin
            if (timer_expire) begin
               if (!sync_2) begin
                  next_state = RECV;
                  timer_load = 1'b1;
                  start_ok   = 1'b1;
               end else begin
                  next_state = IDLE;
               end
            end
         end
         RECV: begin
            if (timer_expire) begin
               shift_bit  = 1'b1;
               timer_load = 1'b1;
               if (bit_cnt == LAST_BIT) begin
                  next_state = STOP_CHK;
               end
            end
         end
         STOP_CHK: begin
            if (timer_expire) begin
               if (!sync_2) begin
                  set_framing = 1'b1;
                  next_state  = IDLE;
               end else if (fifo_if.fifo_full) begin
                  set_overrun = 1'b1;
                  next_state  = IDLE;
               end else begin
                  store_byte = 1'b1;
                  next_state = STORE;
               end
            end
         end
         STORE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Data path: bit counter, LSB-first shift register and the output byte,
   // which only changes when a good frame is committed.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         bit_cnt    <= '0;
         shift_reg  <= '0;
         w_data_reg <= '0;
      end else begin
         if (start_ok) begin
            bit_cnt <= '0;
         end else if (shift_bit) begin
            bit_cnt <= bit_cnt + CW'(1);
         end
         if (shift_bit) begin
            shift_reg <= {sync_2, shift_reg[DATA_BITS-1:1]};
         end
         if (store_byte) begin
            w_data_reg <= shift_reg;
         end
      end
   end

   // Sticky error flags; a new error in the same cycle as a clear wins.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         framing_error <= 1'b0;
         overrun_error <= 1'b0;
      end else begin
         if (set_framing) begin
            framing_error <= 1'b1;
         end else if (clr_error) begin
            framing_error <= 1'b0;
         end
         if (set_overrun) begin
            overrun_error <= 1'b1;
         end else if (clr_error) begin
            overrun_error <= 1'b0;
         end
      end
   end

   assign fifo_if.w_enable = (state == STORE);
   assign fifo_if.w_data   = w_data_reg;
   assign rx_busy          = (state == RECV) || (state == STOP_CHK);

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Self-checking bench for uart_rx_frontend. Frames are driven onto the line
// at known cycles; a timing model derived from the frame format predicts
// when each strobe, flag change and busy window must appear, and a compare
// process checks every output on every cycle.
module tb_uart_rx_frontend;

   localparam int CPB = 10;
   localparam int DB  = 8;

   logic clk       = 1'b0;
   logic n_rst     = 1'b1;
   logic serial_in = 1'b1;
   logic clr_error = 1'b0;
   logic framing_error;
   logic overrun_error;
   logic rx_busy;

   uart_rx_frontend_if #(.DATA_BITS(DB)) fifo_if ();

   uart_rx_frontend #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (DB)
   ) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .serial_in    (serial_in),
      .clr_error    (clr_error),
      .fifo_if      (fifo_if),
      .framing_error(framing_error),
      .overrun_error(overrun_error),
      .rx_busy      (rx_busy)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Cycle index: cycle c is the interval after the c-th rising edge.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [DB-1:0] exp_pulse [int];
   bit            frm_at    [int];
   bit            ovr_at    [int];
   bit            clr_at    [int];
   bit            busy_at   [int];

   int            total = 0;
   int            bad   = 0;
   logic [DB-1:0] m_data = '0;
   logic          m_frm  = 1'b0;
   logic          m_ovr  = 1'b0;
   int            pulse_cnt = 0;
   int            last_pulse_cyc = -1;
   logic [DB-1:0] last_pulse_data = '0;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compare every output against the model once per cycle, away from the edge.
   always begin : compare
      int   c;
      logic exp_we;
      logic exp_busy;
      @(posedge clk);
      #2;
      if (!n_rst) begin
         check_output("rst_w_enable", fifo_if.w_enable, 0);
         check_output("rst_w_data", fifo_if.w_data, 0);
         check_output("rst_framing", framing_error, 0);
         check_output("rst_overrun", overrun_error, 0);
         check_output("rst_busy", rx_busy, 0);
         m_data = '0;
         m_frm  = 1'b0;
         m_ovr  = 1'b0;
         exp_pulse.delete();
         frm_at.delete();
         ovr_at.delete();
         clr_at.delete();
         busy_at.delete();
      end else begin
         c        = cyc;
         exp_we   = exp_pulse.exists(c);
         exp_busy = busy_at.exists(c);
         if (exp_we) m_data = exp_pulse[c];
         if (frm_at.exists(c)) m_frm = 1'b1;
         else if (clr_at.exists(c)) m_frm = 1'b0;
         if (ovr_at.exists(c)) m_ovr = 1'b1;
         else if (clr_at.exists(c)) m_ovr = 1'b0;
         check_output("w_enable", fifo_if.w_enable, exp_we);
         check_output("w_data", fifo_if.w_data, m_data);
         check_output("framing_error", framing_error, m_frm);
         check_output("overrun_error", overrun_error, m_ovr);
         check_output("rx_busy", rx_busy, exp_busy);
         if (fifo_if.w_enable === 1'b1) begin
            pulse_cnt++;
            last_pulse_cyc  = c;
            last_pulse_data = fifo_if.w_data;
         end
      end
   end

   // Drive one frame starting now and record what it must produce. The edge
   // is seen 2 cycles after the line falls (t); the stop bit is sampled at
   // t+95 and its outcome is visible at t+96. A nonzero abort_n asserts
   // reset after that many line cycles.
   task automatic apply_stimulus(input logic [DB-1:0] data, input bit stop, input bit full,
                                 input int stop_len, input int abort_n);
      int          k;
      int          t;
      logic [DB+1:0] frame;
      frame = {stop, data, 1'b0};
      k = cyc;
      t = k + 2;
      for (int c = t + 6; c <= t + 95; c++) busy_at[c] = 1'b1;
      if (!stop) frm_at[t + 96] = 1'b1;
      else if (full) ovr_at[t + 96] = 1'b1;
      else exp_pulse[t + 96] = data;
      for (int n = 0; n < 90 + stop_len; n++) begin
         if (abort_n > 0 && n == abort_n) begin
            n_rst     = 1'b0;
            serial_in = 1'b1;
            repeat (3) tick();
            n_rst = 1'b1;
            return;
         end
         if (n == 3) fifo_if.fifo_full = full;
         serial_in = frame[n / 10];
         tick();
      end
      serial_in = 1'b1;
   endtask

   task automatic pulse_clear();
      clr_error = 1'b1;
      clr_at[cyc + 1] = 1'b1;
      tick();
      clr_error = 1'b0;
   endtask

   // Directed scenarios, then a randomized run.
   initial begin : stimulus
      int   k0;
      int   base;
      bit   b2b;
      logic [DB-1:0] rb;
      bit   rstop;
      bit   rfull;
      fifo_if.fifo_full = 1'b0;
      #1;
      n_rst = 1'b0;
      repeat (5) tick();
      n_rst = 1'b1;
      repeat (50) tick();
      check_output("t1_no_pulse", pulse_cnt, 0);

      k0 = cyc;
      apply_stimulus(8'hA5, 1'b1, 1'b0, 10, 0);
      repeat (5) tick();
      check_output("t2_count", pulse_cnt, 1);
      check_output("t2_data", last_pulse_data, 8'hA5);
      check_output("t2_latency", last_pulse_cyc - k0, 98);

      apply_stimulus(8'h3C, 1'b0, 1'b0, 10, 0);
      repeat (10) tick();
      check_output("t3_framing_held", framing_error, 1);
      check_output("t3_count", pulse_cnt, 1);
      pulse_clear();
      check_output("t3_framing_clr", framing_error, 0);

      apply_stimulus(8'hFF, 1'b1, 1'b1, 10, 0);
      repeat (5) tick();
      check_output("t4_overrun", overrun_error, 1);
      check_output("t4_data_kept", fifo_if.w_data, 8'hA5);
      check_output("t4_count", pulse_cnt, 1);
      fifo_if.fifo_full = 1'b0;
      pulse_clear();

      serial_in = 1'b0;
      repeat (3) tick();
      serial_in = 1'b1;
      repeat (20) tick();
      check_output("t5_glitch_count", pulse_cnt, 1);
      check_output("t5_glitch_flags", {framing_error, overrun_error}, 0);
      apply_stimulus(8'h55, 1'b1, 1'b0, 7, 0);
      apply_stimulus(8'hAA, 1'b1, 1'b0, 10, 0);
      repeat (5) tick();
      check_output("t5_count", pulse_cnt, 3);
      check_output("t5_last", last_pulse_data, 8'hAA);

      apply_stimulus(8'hF0, 1'b1, 1'b0, 10, 55);
      repeat (20) tick();
      check_output("t6_aborted", pulse_cnt, 3);
      apply_stimulus(8'h81, 1'b1, 1'b0, 10, 0);
      repeat (5) tick();
      check_output("t6_count", pulse_cnt, 4);
      check_output("t6_data", last_pulse_data, 8'h81);

      base = pulse_cnt;
      for (int i = 0; i < 25; i++) begin
         rb    = DB'($urandom);
         rstop = ($urandom_range(0, 4) != 0);
         rfull = ($urandom_range(0, 3) == 0);
         b2b   = rstop && ($urandom_range(0, 2) == 0);
         apply_stimulus(rb, rstop, rfull, b2b ? 7 : 10, 0);
         if (!b2b) begin
            repeat ($urandom_range(3, 15)) tick();
            if ($urandom_range(0, 3) == 0) pulse_clear();
            if ($urandom_range(0, 4) == 0) begin
               serial_in = 1'b0;
               repeat ($urandom_range(1, 4)) tick();
               serial_in = 1'b1;
               repeat (10) tick();
            end
         end
      end
      repeat (10) tick();
      check_output("rand_pulses_seen", (pulse_cnt > base) ? 1 : 0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
